// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequences one clear/feed/settle/flag/flush/drain job on an ARRAY_DIM^2 FP MAC array
// Optional job-latency counter enabled by SYSTOLIC_PERF_CNT_EN.
module systolic_array_ctrl #(
  parameter int ARRAY_DIM    = 4,
  parameter int K_WIDTH      = 10,
  parameter int MULT_LAT     = 1,
  parameter int ADD_LAT      = 1,
  parameter int FLUSH_CYCLES = 4,
  parameter int ROW_W        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  output logic                 busy,
  output logic                 pe_clear,
  output logic [ARRAY_DIM-1:0] feed_en,
  output logic [K_WIDTH-1:0]   feed_cnt,
  output logic                 done_flag,
  output logic [ROW_W-1:0]     row_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 job_done,
  output logic [31:0]          perf_cycles
);
  localparam int CW = K_WIDTH + 1;
  localparam logic [7:0] SETTLE_LAST = 8'(MULT_LAT + ADD_LAT - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_DIM - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, SETTLE, FLAG, FLUSH, DRAIN, DONE} state_t;
  state_t r_state;
  logic [K_WIDTH-1:0] r_k;
  logic [CW-1:0] r_fcnt;
  logic [7:0] r_pcnt;
  logic [CW-1:0] w_fnext;
  logic [CW-1:0] w_flen;
  logic [ARRAY_DIM-1:0] w_en;
  // Feed enables are registered, so they are derived from the count of the coming cycle.
  assign w_fnext = (r_state == FEED) ? r_fcnt + CW'(1) : '0;
  assign w_flen = {1'b0, r_k} + CW'(2 * (ARRAY_DIM - 1));
  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_en
    assign w_en[i] = (w_fnext >= CW'(i)) && (w_fnext < CW'(i) + {1'b0, r_k});
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_fcnt    <= '0;
      r_pcnt    <= '0;
      busy      <= 1'b0;
      pe_clear  <= 1'b0;
      feed_en   <= '0;
      feed_cnt  <= '0;
      done_flag <= 1'b0;
      row_sel   <= '0;
      out_valid <= 1'b0;
      job_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_k      <= k_len;
          busy     <= 1'b1;
          pe_clear <= 1'b1;
          r_state  <= CLEAR;
        end
        CLEAR: begin
          pe_clear <= 1'b0;
          if (r_k != '0) begin
            r_state  <= FEED;
            r_fcnt   <= '0;
            feed_cnt <= '0;
            feed_en  <= w_en;
          end else begin
            r_state   <= DRAIN;
            out_valid <= 1'b1;
            row_sel   <= '0;
          end
        end
        FEED: if (r_fcnt == w_flen - CW'(1)) begin
          r_state  <= SETTLE;
          r_pcnt   <= '0;
          feed_en  <= '0;
          feed_cnt <= '0;
        end else begin
          r_fcnt   <= w_fnext;
          feed_en  <= w_en;
          feed_cnt <= w_fnext[K_WIDTH] ? '1 : w_fnext[K_WIDTH-1:0];
        end
        SETTLE: if (r_pcnt == SETTLE_LAST) begin
          r_state   <= FLAG;
          done_flag <= 1'b1;
        end else begin
          r_pcnt <= r_pcnt + 8'd1;
        end
        FLAG: begin
          done_flag <= 1'b0;
          r_pcnt    <= '0;
          r_state   <= FLUSH;
        end
        FLUSH: if (r_pcnt == FLUSH_LAST) begin
          r_state   <= DRAIN;
          out_valid <= 1'b1;
          row_sel   <= '0;
        end else begin
          r_pcnt <= r_pcnt + 8'd1;
        end
        DRAIN: if (out_ready) begin
          if (row_sel == ROW_LAST) begin
            r_state   <= DONE;
            out_valid <= 1'b0;
            row_sel   <= '0;
            job_done  <= 1'b1;
          end else begin
            row_sel <= row_sel + ROW_W'(1);
          end
        end
        DONE: begin
          job_done <= 1'b0;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] r_perf;
  logic [31:0] w_perf_inc;
  assign w_perf_inc = &r_perf ? r_perf : r_perf + 32'd1;
  // The DONE cycle itself is counted, hence the incremented value is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf      <= '0;
      perf_cycles <= '0;
    end else begin
      if (r_state == IDLE && start) r_perf <= '0;
      else if (busy) r_perf <= w_perf_inc;
      if (r_state == DONE) perf_cycles <= w_perf_inc;
    end
  end
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequences one matrix-multiply job on an ARRAY_DIM x ARRAY_DIM systolic array of floating-point multiply-accumulate PEs.
- Each PE has a west/north operand input, a done-flag input that starts its internal partial-sum reduction, and an accumulated-result output.
- The block clears the array, generates the skewed per-row/column operand feed enables, waits for the pipelines to settle, and asserts the done flag.
- After the PE reductions finish, it drains results row-by-row to a consumer over a valid/ready handshake.

Parameters:
- ARRAY_DIM, 4, rows = columns of the PE array.
- K_WIDTH, 10, width of the k_len and feed counters.
- MULT_LAT, 1, FP multiplier latency in cycles.
- ADD_LAT, 1, FP adder latency in cycles.
- FLUSH_CYCLES, 4, cycles from done_flag until PE results are final.
- ROW_W, 2, width of row_sel; must equal clog2(ARRAY_DIM).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job-start pulse; sampled only in IDLE.
- k_len  in  K_WIDTH  inner dimension K; captured on an accepted start.
- busy  out  1  high in every state except IDLE.
- pe_clear  out  1  synchronous clear to all PEs.
- feed_en  out  ARRAY_DIM  bit i enables operand buffers for row i (west) and column i (north).
- feed_cnt  out  K_WIDTH  FEED-phase cycle index; buffer i reads element feed_cnt-i.
- done_flag  out  1  one-cycle pulse driven to all PEs' done-flag inputs.
- row_sel  out  ROW_W  row currently presented to the result mux.
- out_valid  out  1  result row on the array output mux is valid.
- out_ready  in  1  consumer accepts the row.
- job_done  out  1  one-cycle pulse at job completion.
- perf_cycles  out  32  job latency; see Optional Feature.

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- Assertion of reset at any time aborts the current job immediately. No job_done is issued, and no state survives.
- Cycle n below means the cycle whose registered state was set at edge n.

States and transitions:
- IDLE: start=1 latches k_len into k_reg and moves to CLEAR. start in any other state is ignored (no queueing).
- CLEAR: pe_clear=1 for exactly 1 cycle. Next state is FEED if k_reg!=0; otherwise DRAIN (all results read as zero).
- FEED: lasts k_reg+2*(ARRAY_DIM-1) cycles. feed_cnt counts 0 upward. feed_en[i]=1 iff i <= feed_cnt < i+k_reg.
- SETTLE: lasts MULT_LAT+ADD_LAT cycles; feed_en=0.
- FLAG: done_flag=1 for 1 cycle.
- FLUSH: lasts FLUSH_CYCLES cycles.
- DRAIN: out_valid=1, row_sel starts at 0.
  - A row transfers on out_valid&&out_ready; row_sel then increments.
  - row_sel and out_valid hold while out_ready=0.
  - Transfer of row ARRAY_DIM-1 moves to DONE; row_sel wraps to 0.
- DONE: job_done=1 for 1 cycle, then IDLE. busy=0 from the following cycle.

Timing and arithmetic:
- Counters saturate at the FSM bound, never wrap mid-phase.
- Bound comparison in FEED uses K_WIDTH+1 bits so that k_len at its maximum does not overflow.
- Back-to-back jobs: start may be asserted in the cycle after job_done. Minimum inter-job gap is 1 IDLE cycle.

Optional Feature:
- Macro: SYSTOLIC_PERF_CNT_EN.
- Defined:
  - A 32-bit counter clears on an accepted start and increments every cycle busy=1.
  - On job_done it is copied to perf_cycles, which holds until the next job_done.
  - The counter saturates at 2^32-1.
  - Async reset clears it to 0.
- Undefined: no counter logic; perf_cycles is tied to 0.

Test Plan:
- Defaults, K=6, start at edge 0, out_ready=1 -> CLEAR cycle 1; FEED cycles 2-13; feed_en[0] cycles 2-7; feed_en[3] cycles 5-10; done_flag cycle 16; out_valid cycles 21-24 with row_sel 0,1,2,3; job_done cycle 25.
- Same job with out_ready low cycles 21-23, then high -> row 0 held in cycles 21-24; rows transfer cycles 24-27; job_done cycle 28.
- k_len=0 -> CLEAR cycle 1; DRAIN from cycle 2; no feed_en or done_flag ever asserted; job_done cycle 6.
- start pulsed again at cycle 10 of a running job, plus k_len change -> ignored; timing identical to scenario 1; a single job_done.
- reset asserted asynchronously during FEED (cycle 8) -> all outputs 0 before the next edge; FSM in IDLE; no job_done; a new start after release runs normally.
- SYSTOLIC_PERF_CNT_EN defined, scenario 1 -> perf_cycles=25 from cycle 26; undefined -> perf_cycles stays 0.
